// File: rtl/next_pc_unit.sv
// PC sequencer: owns the fetch PC, picks JR/J/branch redirects, and sign-extends the I-type immediate.
// Build option NEXT_PC_UNIT_DELAY_SLOT_EN adds a one-instruction branch delay slot (pend + latched target).
//   pend | meaning
//   0    | normal fetch, redirects may be accepted
//   1    | current pc is a delay slot, pending target applies on the next unstalled edge
module next_pc_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                IMM_W    = 16,
    parameter int                JIDX_W   = 26,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [IMM_W-1:0]  imm,
    input  logic [JIDX_W-1:0] jidx,
    input  logic              br_req,
    input  logic              br_taken,
    input  logic              j_req,
    input  logic              jr_req,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] imm_ext,
    output logic [ADDR_W-1:0] br_target,
    output logic              pend,
    output logic              addr_err
);

    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] redir_target;
    logic              redir_req;
    logic              redir_acc;
    logic              err_nxt;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign imm_ext   = ADDR_W'($signed(imm));
    assign br_target = pc_plus4 + (imm_ext << 2);
    assign j_target  = {pc_plus4[ADDR_W-1:JIDX_W+2], jidx, 2'b00};
    assign jr_target = {jr_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        redir_target = pc_plus4;
        redir_req    = 1'b0;
        if (jr_req) begin
            redir_target = jr_target;
            redir_req    = 1'b1;
        end else if (j_req) begin
            redir_target = j_target;
            redir_req    = 1'b1;
        end else if (br_req && br_taken) begin
            redir_target = br_target;
            redir_req    = 1'b1;
        end
    end

    // A redirect seen while in a delay slot is dropped, including its alignment error.
    assign redir_acc = redir_req && !stall && !pend;
    assign err_nxt   = redir_acc && jr_req && (jr_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= err_nxt;
        end
    end

`ifdef NEXT_PC_UNIT_DELAY_SLOT_EN
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pend_target_nxt;
    logic              pend_nxt;

    always_comb begin
        pc_nxt          = pc;
        pend_nxt        = pend;
        pend_target_nxt = pend_target;
        if (!stall) begin
            if (pend) begin
                pc_nxt   = pend_target;
                pend_nxt = 1'b0;
            end else if (redir_acc) begin
                pc_nxt          = pc_plus4;
                pend_nxt        = 1'b1;
                pend_target_nxt = redir_target;
            end else begin
                pc_nxt = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            pend        <= 1'b0;
            pend_target <= '0;
        end else begin
            pc          <= pc_nxt;
            pend        <= pend_nxt;
            pend_target <= pend_target_nxt;
        end
    end
`else
    assign pend = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (!stall) begin
            pc <= redir_acc ? redir_target : pc_plus4;
        end
    end
`endif

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Parametrised program-counter sequencer for the MIPS core. It owns the PC register and computes next-PC from sequential, conditional-branch, J-type and register-indirect (JR) requests. It also produces the correctly sign-extended immediate for the ALU. It sits between instruction decode and instruction memory, and replaces the combinational field-extension path with a registered, stall-aware unit that can optionally support MIPS branch delay slots.

## Interface

Parameters:
- ADDR_W, 32, PC and target width; ADDR_W >= JIDX_W + 4 required
- IMM_W, 16, width of the I-type immediate field
- JIDX_W, 26, width of the J-type index field
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all state; requests this cycle are not accepted
- imm  in  IMM_W  I-type immediate of the instruction at `pc`
- jidx  in  JIDX_W  J-type index of the instruction at `pc`
- br_req  in  1  instruction at `pc` is a conditional branch
- br_taken  in  1  branch condition true; ignored unless br_req
- j_req  in  1  instruction at `pc` is J/JAL
- jr_req  in  1  instruction at `pc` is JR/JALR
- jr_addr  in  ADDR_W  register operand for JR
- pc  out  ADDR_W  current fetch address (registered)
- pc_plus4  out  ADDR_W  pc + 4 (combinational, for JAL link)
- imm_ext  out  ADDR_W  imm sign-extended to ADDR_W, unshifted (combinational)
- br_target  out  ADDR_W  pc + 4 + (imm_ext << 2), modulo 2^ADDR_W (combinational)
- pend  out  1  redirect pending, i.e. the current pc is a delay slot (registered)
- addr_err  out  1  one-cycle pulse: accepted JR had jr_addr[1:0] != 0 (registered)

## Operation

- imm_ext: replicate imm[IMM_W-1] into bits ADDR_W-1..IMM_W. For example, imm 16'h8000 gives 32'hFFFF_8000.
- Jump target: {pc_plus4[ADDR_W-1:JIDX_W+2], jidx, 2'b00}.
- JR target: {jr_addr[ADDR_W-1:2], 2'b00}. A misaligned jr_addr still redirects to the aligned target and raises addr_err.
- Redirect selection priority: jr_req > j_req > (br_req & br_taken) > none. Only one target is chosen per cycle.
- A request is accepted only when stall = 0.
- When no redirect is in effect, pc advances by pc <= pc + 4, wrapping modulo 2^ADDR_W (all-ones-minus-3 wraps to 0).
- stall = 1: pc, pend and the pending target hold their values, and addr_err is driven 0.
- A redirect request presented while pend = 1 (branch in a delay slot) is ignored. pc still goes to the pending target.

## Timing

- Reset (asynchronous, takes effect immediately): pc = RESET_PC, pend = 0, pending target = 0, addr_err = 0.
- Deassertion of reset: the first pc + 4 step happens on the first rising edge with rst = 0 and stall = 0.
- Without delay slots: a redirect accepted in cycle N gives pc = target in cycle N+1 (latency 1). pend stays 0.
- With delay slots: a redirect accepted in cycle N behaves as follows.
  - Cycle N+1: pc = old pc + 4 and pend = 1. The target is latched.
  - Cycle N+2: pc = target and pend = 0.
  - A stall during N+1 holds both pc and pend.
- addr_err is asserted in the cycle after the accepting edge, for exactly one cycle.
- Reset asserted while pend = 1 discards the pending target.

## Configuration

- Macro: NEXT_PC_UNIT_DELAY_SLOT_EN.
- Defined: MIPS one-instruction branch delay slot, with the pending-target register and pend behaviour above.
- Undefined: redirects apply on the next edge. The pending-target register is not built, and pend is tied to 0.

## Test plan

- Reset/sequential: assert rst, release, 4 free cycles with RESET_PC = 0 -> pc runs 0, 4, 8, 12, 16; pend = 0; addr_err = 0.
- Branch sign extension: pc = 0x100, br_req = 1, br_taken = 1, imm = 16'hFFFE -> br_target = 0xFC and imm_ext = 0xFFFF_FFFE.
  - Macro off: pc = 0xFC next cycle.
  - Macro on: pc = 0x104 with pend = 1, then 0xFC.
- Priority/jump: pc = 0x1000_0000 with jr_req = 1, j_req = 1 and jidx = 26'h1, jr_addr = 0x2000_0003 -> pc = 0x2000_0000 and addr_err pulses 1 cycle. The same test with only j_req = 1 -> pc = 0x1000_0004.
- Stall: issue a taken branch with stall = 1 for 3 cycles -> pc is unchanged and the request is not accepted. Drop stall -> redirect occurs per mode. With the macro on, stall in the delay-slot cycle -> pc and pend hold, then the target is taken.
- Wrap/delay-slot conflict: pc = 0xFFFF_FFFC free-running -> pc = 0. With the macro on, a taken branch in the delay slot -> ignored, and pc goes to the first branch's target.
- Reset mid-redirect: with the macro on and pend = 1, assert rst -> pc = RESET_PC and pend = 0 immediately. No jump to the old target after release.
